// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcode type and values,
// FSM state encoding, and a helper that classifies multi-cycle opcodes.
package alu_pkg;

    typedef logic [5:0] opcode_t;

    localparam opcode_t OP_ADD  = 6'h00;
    localparam opcode_t OP_SUB  = 6'h01;
    localparam opcode_t OP_EQ   = 6'h02;
    localparam opcode_t OP_NE   = 6'h03;
    localparam opcode_t OP_LE   = 6'h04;
    localparam opcode_t OP_GT   = 6'h05;
    localparam opcode_t OP_LLS  = 6'h06;
    localparam opcode_t OP_LRS  = 6'h07;
    localparam opcode_t OP_ARS  = 6'h08;
    localparam opcode_t OP_MUL  = 6'h09;
    localparam opcode_t OP_DIVU = 6'h0A;
    localparam opcode_t OP_REMU = 6'h0B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes served by the bit-serial multiply/divide engine.
    function automatic logic is_muldiv(input opcode_t op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial multiply (shift-add, low WIDTH bits) and restoring unsigned
// divide. Operands load on i_start; one bit is retired per cycle. o_done is
// high during the cycle of the last iteration, and o_lo/o_rem then carry the
// post-iteration values so the caller can capture the final result on that edge.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_rem
);

    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH-1:0] r_acc;   // product accumulator / partial remainder
    logic [WIDTH-1:0] r_x;     // shifted multiplicand / dividend-quotient
    logic [WIDTH-1:0] r_y;     // shifted multiplier / divisor

    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;

    // Next-iteration values for both algorithms sharing the same registers.
    always_comb begin
        w_rem_sh  = {r_acc, r_x[WIDTH-1]};
        w_diff    = w_rem_sh[WIDTH-1:0] - r_y;
        w_acc_nxt = r_acc;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        if (r_div) begin
            if (w_rem_sh >= {1'b0, r_y}) begin
                w_acc_nxt = w_diff;
                w_x_nxt   = {r_x[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_sh[WIDTH-1:0];
                w_x_nxt   = {r_x[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nxt = r_acc + (r_y[0] ? r_x : '0);
            w_x_nxt   = {r_x[WIDTH-2:0], 1'b0};
            w_y_nxt   = {1'b0, r_y[WIDTH-1:1]};
        end
    end

    assign o_done = r_busy && (r_cnt == CW'(WIDTH - 1));
    assign o_lo   = r_div ? w_x_nxt : w_acc_nxt;
    assign o_rem  = w_acc_nxt;

    // Iteration control: busy flag and bit counter, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Datapath registers: load on start, advance one bit while busy.
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_div <= i_div;
            r_acc <= '0;
            r_x   <= i_a;
            r_y   <= i_b;
        end else if (r_busy) begin
            r_acc <= w_acc_nxt;
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU with valid/ready handshakes. Single-cycle ops are computed
// combinationally from the offered operands and registered on the accept
// edge; MUL/DIVU/REMU run through alu_muldiv_iter for WIDTH cycles.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  opcode_t          opCode,
    input  logic             c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans1,
    output logic             ans2,
    output logic             Z,
    output logic             N,
    output logic             dbz,
    output logic             ill
);

    state_t           r_state;
    opcode_t          r_op;

    logic signed [WIDTH-1:0] w_sa;
    logic signed [WIDTH-1:0] w_sb;
    logic [SHW-1:0]   w_sh;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cry;
    logic             w_dbz;
    logic             w_ill;
    logic             w_div_zero;
    logic             w_start;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_rem;
    logic [WIDTH-1:0] w_md_res;

    assign w_sa = a;
    assign w_sb = b;
    assign w_sh = b[SHW-1:0];

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    // Division by zero bypasses the iterative engine entirely.
    assign w_div_zero = ((opCode == OP_DIVU) || (opCode == OP_REMU)) && (b == '0);
    assign w_start    = in_valid && (r_state == ST_IDLE) && is_muldiv(opCode) && !w_div_zero;
    assign w_md_res   = (r_op == OP_REMU) ? w_md_rem : w_md_lo;

    // Single-cycle result and flags for the offered opcode.
    always_comb begin
        w_res = '0;
        w_cry = 1'b0;
        w_dbz = 1'b0;
        w_ill = 1'b0;
        w_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        case (opCode)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_cry = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_res = a - b - {{(WIDTH-1){1'b0}}, c};
                w_cry = ({1'b0, a} >= ({1'b0, b} + {{WIDTH{1'b0}}, c}));
            end
            OP_EQ:   w_res = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_NE:   w_res = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_LE:   w_res = {{(WIDTH-1){1'b0}}, (w_sa <= w_sb)};
            OP_GT:   w_res = {{(WIDTH-1){1'b0}}, (w_sa > w_sb)};
            OP_LLS:  w_res = a << w_sh;
            OP_LRS:  w_res = a >> w_sh;
            OP_ARS:  w_res = w_sa >>> w_sh;
            OP_MUL:  w_res = '0;
            OP_DIVU: begin
                w_res = '1;
                w_dbz = 1'b1;
            end
            OP_REMU: begin
                w_res = a;
                w_dbz = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_div   (opCode != OP_MUL),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_md_done),
        .o_lo    (w_md_lo),
        .o_rem   (w_md_rem)
    );

    // Handshake FSM with registered result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_ADD;
            ans1    <= '0;
            ans2    <= 1'b0;
            Z       <= 1'b0;
            N       <= 1'b0;
            dbz     <= 1'b0;
            ill     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op <= opCode;
                        if (w_start) begin
                            r_state <= ST_CALC;
                        end else begin
                            r_state <= ST_DONE;
                            ans1    <= w_res;
                            ans2    <= w_cry;
                            Z       <= (w_res == '0);
                            N       <= w_res[WIDTH-1];
                            dbz     <= w_dbz;
                            ill     <= w_ill;
                        end
                    end
                end
                ST_CALC: begin
                    if (w_md_done) begin
                        r_state <= ST_DONE;
                        ans1    <= w_md_res;
                        ans2    <= 1'b0;
                        Z       <= (w_md_res == '0);
                        N       <= w_md_res[WIDTH-1];
                        dbz     <= 1'b0;
                        ill     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; legal 8..64, power of two.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), meaning the shift-amount width taken from b.
REQ-003 SHALL have port clk  in  1  sole clock, all state on the rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  an operation is offered.
REQ-006 SHALL have port in_ready  out  1  the block can accept an operation.
REQ-007 SHALL have ports a, b  in  WIDTH  operands.
REQ-008 SHALL have port opCode  in  6  operation select.
REQ-009 SHALL have port c  in  1  carry-in for ADD/SUB.
REQ-010 SHALL have port out_valid  out  1  a result is presented.
REQ-011 SHALL have port out_ready  in  1  the consumer takes the result.
REQ-012 SHALL have port ans1  out  WIDTH  result.
REQ-013 SHALL have ports ans2, Z, N, dbz, ill  out  1 each  carry/no-borrow, zero, negative, divide-by-zero, illegal opcode.

Function
REQ-014 SHALL accept an operation on a rising edge with in_valid=1 and in_ready=1, registering a, b, opCode and c.
REQ-015 SHALL use opcodes 0x00 ADD (a+b+c), 0x01 SUB (a-b-c), 0x02 EQ, 0x03 NE, 0x04 LE (signed a<=b), 0x05 GT (signed a>b), 0x06 LLS, 0x07 LRS, 0x08 ARS, 0x09 MUL (low WIDTH bits, unsigned), 0x0A DIVU quotient, 0x0B REMU remainder.
REQ-016 SHALL produce 1 or 0 in ans1 for the compare ops; shift ops SHALL use b[SHW-1:0] only.
REQ-017 SHALL set ans2 to the carry-out for ADD, to 1 when a >= b+c unsigned (no borrow) for SUB, and to 0 otherwise.
REQ-018 SHALL set Z = (ans1==0) and N = ans1[WIDTH-1] for every operation.
REQ-019 SHALL implement a 3-state FSM: IDLE (in_ready=1), CALC, DONE (out_valid=1); in_ready SHALL be 0 outside IDLE.
REQ-020 SHALL move single-cycle ops IDLE->DONE on acceptance, so out_valid rises in the cycle after the accept edge.
REQ-021 SHALL move MUL/DIVU/REMU IDLE->CALC, iterate one bit per cycle (shift-add multiply, restoring divide) for exactly WIDTH cycles, then enter DONE; out_valid rises WIDTH+1 cycles after the accept edge.
REQ-022 SHALL hold ans1 and all flags stable in DONE until a rising edge with out_ready=1, then return to IDLE; back-to-back acceptance in that same edge SHALL NOT occur.
REQ-023 SHALL, for DIVU/REMU with b==0, skip iteration, go to DONE next cycle, output quotient all-ones / remainder = a, and set dbz=1.
REQ-024 SHALL treat undefined opcodes as single-cycle with ans1=0, ans2=0, ill=1; dbz and ill SHALL be 0 for all other results.
REQ-025 SHALL ignore in_valid and operand changes while not in IDLE.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-CALC, immediately force IDLE, in_ready=1, out_valid=0, ans1=0, ans2=Z=N=dbz=ill=0 (Z=0 until first result), and abort any iteration.
REQ-027 SHALL accept no operation on the edge coinciding with or while rst=1.

Structure
REQ-028 SHALL take opcode constants, FSM state encoding and the 6-bit opcode type from shared package alu_pkg.
REQ-029 SHALL place the iterative multiply/divide datapath in one sub-module alu_muldiv_iter (start, done handshake, WIDTH parameter); single-cycle ops SHALL stay in alu_iter.

Verification
REQ-030 SHALL cover ADD a=0xFFFFFFFF, b=0x00000001, c=0 -> ans1=0, ans2=1, Z=1, N=0, out_valid one cycle after accept.
REQ-031 SHALL cover MUL a=0x00010000, b=0x00010001 -> ans1=0x00010000, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-032 SHALL cover DIVU a=100, b=7 -> ans1=14; REMU same operands -> ans1=2; DIVU b=0 -> ans1=0xFFFFFFFF, dbz=1.
REQ-033 SHALL cover ARS a=0x80000000, b=0x00000024 (shift 4) -> ans1=0xF8000000, N=1; GT a=0xFFFFFFFF, b=0 -> ans1=0.
REQ-034 SHALL cover out_ready held 0 for 5 cycles after DONE -> ans1/flags constant, new in_valid ignored; rst asserted mid-CALC -> outputs cleared immediately, next accept behaves normally.
REQ-035 SHALL cover opcode 0x3F -> ans1=0, ill=1, single-cycle latency; rerun REQ-030/032 with WIDTH=8 (ADD 0xFF+0x01 -> 0x00, ans2=1).
